conv2d_img2col_stream: RTL and testbench

//  Sequential, multi-channel successor to the combinational img2col unpacker.

---
 rtl/conv2d_pkg.sv | 52 +++++
 rtl/conv2d_window_gen.sv | 89 ++++++++
 rtl/conv2d_img2col_stream.sv | 147 ++++++++++++++
 tb/tb_conv2d_img2col_stream.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// conv2d_pkg: state encoding and output-shape helpers
// shared by the img2col stream unit and its window generator.
package conv2d_pkg;

  typedef logic [1:0] state_t;

  localparam state_t LOAD   = 2'd0;
  localparam state_t GATHER = 2'd1;
  localparam state_t EMIT   = 2'd2;

  // Output map extent along one axis (floor division).
  function automatic int out_dim(
    input int img,
    input int k,
    input int pad,
    input int stride
  );
    if (stride < 1) return 0;
    return (img + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int n_patch(
    input int iw,
    input int ih,
    input int kw,
    input int kh,
    input int pad,
    input int stride
  );
    return out_dim(iw, kw, pad, stride) *
           out_dim(ih, kh, pad, stride);
  endfunction

  // Index width for a counter over n values, never zero.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(
    input int iw,
    input int ih,
    input int kw,
    input int kh,
    input int pad,
    input int stride
  );
    return (pad < kw) && (pad < kh) && (stride >= 1) &&
           (out_dim(iw, kw, pad, stride) >= 1) &&
           (out_dim(ih, kh, pad, stride) >= 1);
  endfunction

endpackage

// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen: output-map row/col counters and the
// source coordinates of the patch about to be registered.
module conv2d_window_gen
  import conv2d_pkg::*;
#(
  parameter int IMAGE_WIDTH   = 5,
  parameter int IMAGE_HEIGHT  = 5,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int WEIGHT_HEIGHT = 3,
  parameter int PADDING       = 0,
  parameter int STRIDE        = 1,
  parameter int AW            = 5,
  parameter int RW            = 2,
  parameter int CW            = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  adv_i,
  output logic [RW-1:0]         row_o,
  output logic [CW-1:0]         col_o,
  output logic                  last_o,
  output logic [WEIGHT_HEIGHT*WEIGHT_WIDTH-1:0][AW-1:0] addr_o,
  output logic [WEIGHT_HEIGHT*WEIGHT_WIDTH-1:0]         inb_o
);

  localparam int OUT_W =
    out_dim(IMAGE_WIDTH, WEIGHT_WIDTH, PADDING, STRIDE);
  localparam int OUT_H =
    out_dim(IMAGE_HEIGHT, WEIGHT_HEIGHT, PADDING, STRIDE);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  int            sr, sc;

  // Position of the patch loaded at the next edge.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_q == CW'(OUT_W - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Current patch position register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Per-element source pixel index and in-image mask.
  always_comb begin
    addr_o = '0;
    inb_o  = '0;
    sr     = 0;
    sc     = 0;
    for (int kh = 0; kh < WEIGHT_HEIGHT; kh++) begin
      for (int kw = 0; kw < WEIGHT_WIDTH; kw++) begin
        sr = int'(row_d) * STRIDE + kh - PADDING;
        sc = int'(col_d) * STRIDE + kw - PADDING;
        if (sr >= 0 && sr < IMAGE_HEIGHT &&
            sc >= 0 && sc < IMAGE_WIDTH) begin
          inb_o[kh*WEIGHT_WIDTH+kw]  = 1'b1;
          addr_o[kh*WEIGHT_WIDTH+kw] =
            AW'(sr * IMAGE_WIDTH + sc);
        end
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == RW'(OUT_H - 1)) &&
                  (col_q == CW'(OUT_W - 1));

endmodule

// File: rtl/conv2d_img2col_stream.sv
// conv2d_img2col_stream: buffers one frame from a pixel stream,
// then streams flattened zero-padded conv patches.
module conv2d_img2col_stream
  import conv2d_pkg::*;
#(
  parameter int BITWIDTH      = 8,
  parameter int CHANNELS      = 1,
  parameter int IMAGE_WIDTH   = 5,
  parameter int IMAGE_HEIGHT  = 5,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int WEIGHT_HEIGHT = 3,
  parameter int PADDING       = 0,
  parameter int STRIDE        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_pixel,
  output logic out_valid,
  input  logic out_ready,
  output logic [WEIGHT_HEIGHT*WEIGHT_WIDTH*CHANNELS*BITWIDTH-1:0]
               out_patch,
  output logic [idx_w(out_dim(IMAGE_HEIGHT, WEIGHT_HEIGHT,
                              PADDING, STRIDE))-1:0] out_row,
  output logic [idx_w(out_dim(IMAGE_WIDTH, WEIGHT_WIDTH,
                              PADDING, STRIDE))-1:0] out_col,
  output logic out_last
);

  localparam int OUT_W =
    out_dim(IMAGE_WIDTH, WEIGHT_WIDTH, PADDING, STRIDE);
  localparam int OUT_H =
    out_dim(IMAGE_HEIGHT, WEIGHT_HEIGHT, PADDING, STRIDE);
  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int NW   = WEIGHT_WIDTH * WEIGHT_HEIGHT;
  localparam int NE   = NW * CHANNELS;
  localparam int PW   = CHANNELS * BITWIDTH;
  localparam int AW   = idx_w(NPIX);
  localparam int RW   = idx_w(OUT_H);
  localparam int CW   = idx_w(OUT_W);

  if (!params_ok(IMAGE_WIDTH, IMAGE_HEIGHT, WEIGHT_WIDTH,
                 WEIGHT_HEIGHT, PADDING, STRIDE)) begin : g_chk
    $error("conv2d_img2col_stream: illegal geometry");
  end

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       fbuf_q [NPIX];
  logic [NE*BITWIDTH-1:0] patch_q, patch_d;
  logic [PW-1:0]       px;
  logic                hs_in, hs_out, last_pix;
  logic                win_last, start, adv;
  logic [NW-1:0][AW-1:0] addr;
  logic [NW-1:0]       inb;

  assign hs_in    = in_valid && in_ready;
  assign hs_out   = out_valid && out_ready;
  assign last_pix = (cnt_q == AW'(NPIX - 1));
  assign start    = (state_q == GATHER);
  assign adv      = hs_out && !win_last;

  conv2d_window_gen #(
    .IMAGE_WIDTH   (IMAGE_WIDTH),
    .IMAGE_HEIGHT  (IMAGE_HEIGHT),
    .WEIGHT_WIDTH  (WEIGHT_WIDTH),
    .WEIGHT_HEIGHT (WEIGHT_HEIGHT),
    .PADDING       (PADDING),
    .STRIDE        (STRIDE),
    .AW            (AW),
    .RW            (RW),
    .CW            (CW)
  ) u_win (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .adv_i   (adv),
    .row_o   (out_row),
    .col_o   (out_col),
    .last_o  (win_last),
    .addr_o  (addr),
    .inb_o   (inb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (hs_in && last_pix) state_d = GATHER;
      GATHER:  state_d = EMIT;
      EMIT:    if (hs_out && win_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == EMIT);
  end

  // Pixel counter advances only on accepted beats.
  always_comb begin
    cnt_d = cnt_q;
    if (hs_in) cnt_d = last_pix ? '0 : cnt_q + AW'(1);
  end

  // Counter and patch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      patch_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (start || adv) patch_q <= patch_d;
    end
  end

  // Frame buffer write port.
  always_ff @(posedge clk) begin
    if (hs_in) fbuf_q[cnt_q] <= in_pixel;
  end

  // Patch mux: element 0 lands in the MSBs, channel 0 first.
  always_comb begin
    patch_d = '0;
    px      = '0;
    for (int k = 0; k < NW; k++) begin
      px = inb[k] ? fbuf_q[addr[k]] : '0;
      for (int c = 0; c < CHANNELS; c++) begin
        patch_d[(NE-1-(k*CHANNELS+c))*BITWIDTH +: BITWIDTH] =
          px[(CHANNELS-1-c)*BITWIDTH +: BITWIDTH];
      end
    end
  end

  assign out_patch = patch_q;
  assign out_last  = win_last && out_valid;

endmodule

// File: tb/tb_conv2d_img2col_stream.sv
// tb_conv2d_img2col_stream: four geometries of the img2col
// stream unit driven in lockstep and checked against a model.
module tb_conv2d_img2col_stream;

  localparam int PADV [4] = '{0, 1, 0, 1};
  localparam int STRV [4] = '{1, 1, 2, 2};
  localparam int CHV  [4] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [15:0] pix16;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        l0, l1, l2, l3;
  logic [71:0] op0, op1, op2;
  logic [143:0] op3;
  logic [1:0]  r0, c0, r3, c3;
  logic [2:0]  r1, c1;
  logic [0:0]  r2, c2;

  logic         ova [4];
  logic         ira [4];
  logic         la  [4];
  logic [143:0] opa [4];
  logic [7:0]   ra  [4];
  logic [7:0]   ca  [4];

  logic [15:0]  img [25];
  logic [143:0] got [4][25];
  int errors = 0;
  int checks = 0;

  logic [7:0] spec_img [25] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
    8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
    8'h0B, 8'h0C, 8'h0D, 8'h0C, 8'h0B,
    8'h0A, 8'h09, 8'h08, 8'h07, 8'h06,
    8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

  conv2d_img2col_stream #(
    .BITWIDTH(8), .CHANNELS(1), .IMAGE_WIDTH(5),
    .IMAGE_HEIGHT(5), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3),
    .PADDING(0), .STRIDE(1)
  ) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(ir0), .in_pixel(pix16[7:0]),
    .out_valid(ov0), .out_ready(out_ready),
    .out_patch(op0), .out_row(r0), .out_col(c0),
    .out_last(l0));

  conv2d_img2col_stream #(
    .BITWIDTH(8), .CHANNELS(1), .IMAGE_WIDTH(5),
    .IMAGE_HEIGHT(5), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3),
    .PADDING(1), .STRIDE(1)
  ) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(ir1), .in_pixel(pix16[7:0]),
    .out_valid(ov1), .out_ready(out_ready),
    .out_patch(op1), .out_row(r1), .out_col(c1),
    .out_last(l1));

  conv2d_img2col_stream #(
    .BITWIDTH(8), .CHANNELS(1), .IMAGE_WIDTH(5),
    .IMAGE_HEIGHT(5), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3),
    .PADDING(0), .STRIDE(2)
  ) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(ir2), .in_pixel(pix16[7:0]),
    .out_valid(ov2), .out_ready(out_ready),
    .out_patch(op2), .out_row(r2), .out_col(c2),
    .out_last(l2));

  conv2d_img2col_stream #(
    .BITWIDTH(8), .CHANNELS(2), .IMAGE_WIDTH(5),
    .IMAGE_HEIGHT(5), .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3),
    .PADDING(1), .STRIDE(2)
  ) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(ir3), .in_pixel(pix16),
    .out_valid(ov3), .out_ready(out_ready),
    .out_patch(op3), .out_row(r3), .out_col(c3),
    .out_last(l3));

  always_comb begin
    ova[0] = ov0; ova[1] = ov1; ova[2] = ov2; ova[3] = ov3;
    ira[0] = ir0; ira[1] = ir1; ira[2] = ir2; ira[3] = ir3;
    la[0]  = l0;  la[1]  = l1;  la[2]  = l2;  la[3]  = l3;
    opa[0] = {72'b0, op0};
    opa[1] = {72'b0, op1};
    opa[2] = {72'b0, op2};
    opa[3] = op3;
    ra[0] = 8'(r0); ra[1] = 8'(r1);
    ra[2] = 8'(r2); ra[3] = 8'(r3);
    ca[0] = 8'(c0); ca[1] = 8'(c1);
    ca[2] = 8'(c2); ca[3] = 8'(c3);
  end

  function automatic int nout(input int d);
    return (5 + 2 * PADV[d] - 3) / STRV[d] + 1;
  endfunction

  // Reference patch from window geometry over the stored image.
  function automatic logic [143:0] exp_patch(
    input int d, input int r, input int c);
    logic [143:0] p;
    logic [15:0]  v;
    int pos, sr, sc, n;
    p = '0;
    pos = 0;
    n = 9 * CHV[d];
    for (int kh = 0; kh < 3; kh++) begin
      for (int kw = 0; kw < 3; kw++) begin
        sr = r * STRV[d] + kh - PADV[d];
        sc = c * STRV[d] + kw - PADV[d];
        v = (sr >= 0 && sr < 5 && sc >= 0 && sc < 5) ?
            img[sr*5+sc] : 16'h0;
        if (CHV[d] == 1) begin
          p[(n-1-pos)*8 +: 8] = v[7:0];
          pos = pos + 1;
        end else begin
          p[(n-1-pos)*8 +: 8] = v[15:8];
          p[(n-2-pos)*8 +: 8] = v[7:0];
          pos = pos + 2;
        end
      end
    end
    return p;
  endfunction

  task automatic rand_img();
    for (int i = 0; i < 25; i++) img[i] = 16'($urandom);
  endtask

  // Drives npix beats with random idle gaps; entered at posedge+1.
  task automatic load_frame(input int npix, input int gap);
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        pix16 = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      pix16 = img[i];
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (ira[d] !== 1'b1 || ova[d] !== 1'b0) begin
          errors++;
          $display("FAIL load dut%0d pix%0d rdy=%b vld=%b want 1/0",
                   d, i, ira[d], ova[d]);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Gather cycle then full patch stream of every instance.
  task automatic emit_frame(input bit rnd, input bit pulse);
    int idx [4];
    bit done [4];
    bit post [4];
    int cyc, n, ow;
    bit all, any_done;
    logic [143:0] e;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      idx[d] = 0; done[d] = 1'b0; post[d] = 1'b0;
      checks++;
      if (ova[d] !== 1'b0 || ira[d] !== 1'b0) begin
        errors++;
        $display("FAIL gather dut%0d vld=%b rdy=%b want 0/0",
                 d, ova[d], ira[d]);
      end
    end
    cyc = 0;
    all = 1'b0;
    while (!all && cyc < 2000) begin
      @(posedge clk); #1;
      any_done = done[0] | done[1] | done[2] | done[3];
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      in_valid = pulse && !any_done && ($urandom_range(1) == 1);
      pix16 = 16'($urandom);
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 4; d++) begin
        if (post[d]) continue;
        ow = nout(d);
        n = ow * ow;
        if (done[d]) begin
          checks++;
          if (ova[d] !== 1'b0 || ira[d] !== 1'b1) begin
            errors++;
            $display("FAIL reload dut%0d vld=%b rdy=%b want 0/1",
                     d, ova[d], ira[d]);
          end
          post[d] = 1'b1;
        end else begin
          checks++;
          if (ova[d] !== 1'b1 || ira[d] !== 1'b0) begin
            errors++;
            $display("FAIL stream dut%0d p%0d vld=%b rdy=%b want 1/0",
                     d, idx[d], ova[d], ira[d]);
          end else begin
            e = exp_patch(d, idx[d] / ow, idx[d] % ow);
            checks++;
            if (opa[d] !== e ||
                ra[d] !== 8'(idx[d] / ow) ||
                ca[d] !== 8'(idx[d] % ow) ||
                la[d] !== (idx[d] == n - 1)) begin
              errors++;
              $display("FAIL patch dut%0d p%0d got %h r%0d c%0d l%b want %h r%0d c%0d l%b",
                       d, idx[d], opa[d], ra[d], ca[d], la[d],
                       e, idx[d] / ow, idx[d] % ow,
                       idx[d] == n - 1);
            end
            if (out_ready) begin
              got[d][idx[d]] = opa[d];
              idx[d]++;
              if (idx[d] == n) done[d] = 1'b1;
            end
          end
        end
      end
      all = post[0] && post[1] && post[2] && post[3];
    end
    checks++;
    if (!all) begin
      errors++;
      $display("FAIL timeout emit cycles=%0d want < 2000", cyc);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ira[d] !== 1'b1 || ova[d] !== 1'b0 ||
          opa[d] !== '0 || ra[d] !== 8'd0 ||
          ca[d] !== 8'd0 || la[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d rdy=%b vld=%b p=%h r=%0d c=%0d l=%b want 1/0/0/0/0/0",
                 d, ira[d], ova[d], opa[d], ra[d], ca[d], la[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 25; i++)
      img[i] = {~spec_img[i], spec_img[i]};
    load_frame(25, 0);
    emit_frame(1'b0, 1'b0);
    checks++;
    if (got[0][0] !== 144'h0102030607080B0C0D) begin
      errors++;
      $display("FAIL p0_first got %h want 0102030607080b0c0d",
               got[0][0]);
    end
    checks++;
    if (got[0][8] !== 144'h0D0C0B080706030201) begin
      errors++;
      $display("FAIL p0_last got %h want 0d0c0b080706030201",
               got[0][8]);
    end
    checks++;
    if (got[1][0] !== 144'h000000000102000607) begin
      errors++;
      $display("FAIL p1_00 got %h want 000000000102000607",
               got[1][0]);
    end
    checks++;
    if (got[1][24] !== 144'h070600020100000000) begin
      errors++;
      $display("FAIL p1_44 got %h want 070600020100000000",
               got[1][24]);
    end
    checks++;
    if (got[2][1] !== 144'h03040508090A0D0C0B) begin
      errors++;
      $display("FAIL s2_01 got %h want 03040508090a0d0c0b",
               got[2][1]);
    end
    checks++;
    if (got[3][0] !==
        144'h0000000000000000FE01FD020000F906F807) begin
      errors++;
      $display("FAIL c2_00 got %h want 0000fe01fd020000f906f807",
               got[3][0]);
    end
  endtask

  task automatic test_backpressure();
    repeat (3) begin
      rand_img();
      load_frame(25, 30);
      emit_frame(1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) begin
      rand_img();
      load_frame(25, 0);
      emit_frame(1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_load();
    rand_img();
    load_frame(10, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ova[d] !== 1'b0 || ira[d] !== 1'b1) begin
        errors++;
        $display("FAIL rst_load dut%0d vld=%b rdy=%b want 0/1",
                 d, ova[d], ira[d]);
      end
    end
    @(posedge clk); #1;
    rand_img();
    load_frame(25, 0);
    emit_frame(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_emit();
    rand_img();
    load_frame(25, 0);
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ova[d] !== 1'b0 || ira[d] !== 1'b1 ||
          opa[d] !== '0 || ra[d] !== 8'd0 ||
          ca[d] !== 8'd0 || la[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_emit dut%0d vld=%b rdy=%b p=%h r=%0d c=%0d want 0/1/0/0/0",
                 d, ova[d], ira[d], opa[d], ra[d], ca[d]);
      end
    end
    @(posedge clk); #1;
    rand_img();
    load_frame(25, 10);
    emit_frame(1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    pix16 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
